serv_wb_byte_bridge: RTL and testbench

- Wishbone slave that sits directly downstream of the SERV data-bus master. It consumes the master's 32-bit word-aligned address, write data, byte selects, write enable and cycle strobe.
- Serialises each access into byte-wide accesses on a synchronous single-port byte SRAM with 1-cycle read latency.
- Assembles read data into a 32-bit word and returns a single-cycle ack.
- Lets SERV run from small 8-bit-wide on-chip RAMs.

---
 rtl/serv_wb_byte_bridge.sv | 129 ++++++++++++
 tb/tb_serv_wb_byte_bridge.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serv_wb_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module   : serv_wb_byte_bridge
// Purpose  : SERV Wishbone data-bus slave that serialises each word access
//            into byte accesses on a 1-cycle-latency byte SRAM.
//            Optional macro SERV_BYTE_BRIDGE_SKIP_EN skips unselected lanes.
// Revision : 1.0 - initial release
// ============================================================================
module serv_wb_byte_bridge #(
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [31:0]   i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [AW-1:0] o_mem_adr,
  output logic [7:0]    o_mem_wdat,
  output logic          o_mem_we,
  output logic          o_mem_en,
  input  logic [7:0]    i_mem_rdt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-3:0] adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic [1:0]    lane_dly_q;
  logic          rd_vld_q;
  logic [31:0]   rdt_q;

  // Lane index 4 (bit 2 set) means "no lane left", i.e. head for CAPT.
  logic [2:0]    w_start_lane;
  logic [2:0]    w_next_lane;
  logic          w_mem_en;
  logic          w_unused;

`ifdef SERV_BYTE_BRIDGE_SKIP_EN
  function automatic logic [2:0] first_lane(input logic [3:0] sel, input logic [2:0] from);
    logic [2:0] lane;
    lane = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (sel[i] && (3'(i) >= from)) lane = 3'(i);
    end
    return lane;
  endfunction

  assign w_start_lane = first_lane(i_wb_sel, 3'd0);
  assign w_next_lane  = first_lane(sel_q, {1'b0, cnt_q} + 3'd1);
`else
  assign w_start_lane = 3'd0;
  assign w_next_lane  = {1'b0, cnt_q} + 3'd1;
`endif

  assign w_unused = ^{i_wb_adr[31:AW], i_wb_adr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_wb_cyc) begin
          if (w_start_lane[2]) begin
            state_d = S_CAPT;
          end else begin
            state_d = S_XFER;
            cnt_d   = w_start_lane[1:0];
          end
        end
      end
      S_XFER: begin
        if (w_next_lane[2]) state_d = S_CAPT;
        else                cnt_d   = w_next_lane[1:0];
      end
      S_CAPT:  state_d = S_ACK;
      default: state_d = S_IDLE;
    endcase
  end

  assign w_mem_en = (state_q == S_XFER) & sel_q[cnt_q];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      adr_q      <= '0;
      dat_q      <= 32'd0;
      sel_q      <= 4'd0;
      we_q       <= 1'b0;
      lane_dly_q <= 2'd0;
      rd_vld_q   <= 1'b0;
      rdt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_dly_q <= cnt_q;
      rd_vld_q   <= w_mem_en & ~we_q;
      if (state_q == S_IDLE && i_wb_cyc) begin
        adr_q <= i_wb_adr[AW-1:2];
        dat_q <= i_wb_dat;
        sel_q <= i_wb_sel;
        we_q  <= i_wb_we;
        rdt_q <= 32'd0;
      end else if (rd_vld_q) begin
        rdt_q[{lane_dly_q, 3'b000} +: 8] <= i_mem_rdt;
      end
    end
  end

  assign o_wb_rdt   = rdt_q;
  assign o_wb_ack   = (state_q == S_ACK);
  assign o_mem_adr  = {adr_q, cnt_q};
  assign o_mem_wdat = dat_q[{cnt_q, 3'b000} +: 8];
  assign o_mem_we   = w_mem_en & we_q;
  assign o_mem_en   = w_mem_en;

endmodule
`default_nettype wire

// File: tb/tb_serv_wb_byte_bridge.sv
`default_nettype none
// Directed self-checking bench for serv_wb_byte_bridge with a byte-SRAM model.
module tb_serv_wb_byte_bridge;

`ifdef SERV_BYTE_BRIDGE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_wb_adr = 32'd0;
  logic [31:0] i_wb_dat = 32'd0;
  logic [3:0]  i_wb_sel = 4'd0;
  logic        i_wb_we  = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic [9:0]  o_mem_adr;
  logic [7:0]  o_mem_wdat;
  logic        o_mem_we;
  logic        o_mem_en;
  logic [7:0]  mem_rdt = 8'd0;

  int compared   = 0;
  int mismatched = 0;
  int requests   = 0;
  int acks       = 0;

  logic [7:0] mem [0:1023];
  logic [9:0] log_adr [$];
  logic [7:0] log_dat [$];
  logic       log_we  [$];

  always #5 i_clk = ~i_clk;

  serv_wb_byte_bridge #(.AW(10)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wb_adr   (i_wb_adr),
    .i_wb_dat   (i_wb_dat),
    .i_wb_sel   (i_wb_sel),
    .i_wb_we    (i_wb_we),
    .i_wb_cyc   (i_wb_cyc),
    .o_wb_rdt   (o_wb_rdt),
    .o_wb_ack   (o_wb_ack),
    .o_mem_adr  (o_mem_adr),
    .o_mem_wdat (o_mem_wdat),
    .o_mem_we   (o_mem_we),
    .o_mem_en   (o_mem_en),
    .i_mem_rdt  (mem_rdt)
  );

  // Synchronous byte SRAM, one-cycle read latency, with a strobe log.
  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) mem[o_mem_adr] <= o_mem_wdat;
      else          mem_rdt <= mem[o_mem_adr];
      log_adr.push_back(o_mem_adr);
      log_dat.push_back(o_mem_wdat);
      log_we.push_back(o_mem_we);
    end
    if (o_wb_ack) acks <= acks + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [9:0] adr,
                         input logic [7:0] dat, input logic we);
    chk({tag, "_present"}, 32'(idx < log_adr.size()), 32'd1);
    if (idx < log_adr.size()) begin
      chk({tag, "_adr"}, 32'(log_adr[idx]), 32'(adr));
      chk({tag, "_we"},  32'(log_we[idx]),  32'(we));
      if (we) chk({tag, "_dat"}, 32'(log_dat[idx]), 32'(dat));
    end
  endtask

  // One Wishbone request; inputs are scrambled after acceptance.
  task automatic access(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we, input int lat_full,
                        input int lat_skip, input logic [31:0] exp_rdt);
    int lat;
    logic [31:0] rd;
    lat = 0;
    rd  = 32'hxxxx_xxxx;
    @(negedge i_clk);
    chk({tag, "_idle_ack"}, 32'(o_wb_ack), 32'd0);
    i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel; i_wb_we = we; i_wb_cyc = 1'b1;
    requests++;
    @(negedge i_clk);
    i_wb_adr = ~adr; i_wb_dat = ~dat; i_wb_sel = ~sel; i_wb_we = ~we;
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) @(negedge i_clk);
      if (o_wb_ack) begin
        lat = n;
        rd  = o_wb_rdt;
        break;
      end
    end
    i_wb_cyc = 1'b0; i_wb_adr = 32'd0; i_wb_dat = 32'd0; i_wb_sel = 4'd0; i_wb_we = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(SKIP ? lat_skip : lat_full));
    chk({tag, "_rdt"}, rd, exp_rdt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    logic saw;

    repeat (3) @(negedge i_clk);
    chk("reset_ack",    32'(o_wb_ack), 32'd0);
    chk("reset_rdt",    o_wb_rdt,      32'd0);
    chk("reset_mem_en", 32'(o_mem_en), 32'd0);
    chk("reset_mem_we", 32'(o_mem_we), 32'd0);
    i_rst = 1'b0;

    // Word write: four ascending strobes, ack in cycle 6.
    base = log_adr.size();
    access("wr_word", 32'h0000_0010, 32'hA1B2C3D4, 4'b1111, 1'b1, 6, 6, 32'd0);
    chk("wr_word_nstrobe", 32'(log_adr.size() - base), 32'd4);
    chk_log("wr_word_l0", base + 0, 10'h010, 8'hD4, 1'b1);
    chk_log("wr_word_l1", base + 1, 10'h011, 8'hC3, 1'b1);
    chk_log("wr_word_l2", base + 2, 10'h012, 8'hB2, 1'b1);
    chk_log("wr_word_l3", base + 3, 10'h013, 8'hA1, 1'b1);
    chk("wr_word_mem", {mem[10'h013], mem[10'h012], mem[10'h011], mem[10'h010]}, 32'hA1B2C3D4);

    // Word read after preload.
    access("pre_20", 32'h0000_0020, 32'h44332211, 4'b1111, 1'b1, 6, 6, 32'd0);
    access("rd_word", 32'h0000_0020, 32'h0, 4'b1111, 1'b0, 6, 6, 32'h44332211);

    // Single byte write in lane 2, then full readback.
    access("pre_08", 32'h0000_0008, 32'h04030201, 4'b1111, 1'b1, 6, 6, 32'd0);
    base = log_adr.size();
    access("wr_byte", 32'h0000_0008, 32'h00EE0000, 4'b0100, 1'b1, 6, 3, 32'd0);
    chk("wr_byte_nstrobe", 32'(log_adr.size() - base), 32'd1);
    chk_log("wr_byte_l2", base, 10'h00A, 8'hEE, 1'b1);
    access("rd_byte_back", 32'h0000_0008, 32'h0, 4'b1111, 1'b0, 6, 6, 32'h04EE0201);

    // Upper halfword read; low lanes must read as zero.
    access("pre_30", 32'h0000_0030, 32'h90807060, 4'b1111, 1'b1, 6, 6, 32'd0);
    base = log_adr.size();
    access("rd_half", 32'h0000_0030, 32'h0, 4'b1100, 1'b0, 6, 4, 32'h90800000);
    chk("rd_half_nstrobe", 32'(log_adr.size() - base), 32'd2);
    chk_log("rd_half_l2", base + 0, 10'h032, 8'h00, 1'b0);
    chk_log("rd_half_l3", base + 1, 10'h033, 8'h00, 1'b0);

    // Empty byte select: no strobes, zero data.
    base = log_adr.size();
    access("rd_sel0", 32'h0000_0050, 32'h0, 4'b0000, 1'b0, 6, 2, 32'd0);
    chk("rd_sel0_nstrobe", 32'(log_adr.size() - base), 32'd0);

    // Address bits above AW alias back into the SRAM.
    base = log_adr.size();
    access("rd_alias", 32'h0000_1020, 32'h0, 4'b1111, 1'b0, 6, 6, 32'h44332211);
    chk_log("rd_alias_l0", base, 10'h020, 8'h00, 1'b0);

    // Reset during cycle 3 of a write aborts it.
    access("pre_40", 32'h0000_0040, 32'h00000000, 4'b1111, 1'b1, 6, 6, 32'd0);
    access("pre_3fc", 32'h0000_03FC, 32'hEFBEADDE, 4'b1111, 1'b1, 6, 6, 32'd0);
    base = log_adr.size();
    @(negedge i_clk);
    i_wb_adr = 32'h40; i_wb_dat = 32'h55667788; i_wb_sel = 4'hF; i_wb_we = 1'b1; i_wb_cyc = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1; i_wb_cyc = 1'b0;
    @(negedge i_clk);
    chk("rst_mid_mem_en", 32'(o_mem_en), 32'd0);
    chk("rst_mid_ack",    32'(o_wb_ack), 32'd0);
    i_rst = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge i_clk);
      saw = saw | o_wb_ack | o_mem_en;
    end
    chk("rst_mid_quiet",   32'(saw), 32'd0);
    chk("rst_mid_nstrobe", 32'(log_adr.size() - base), 32'd3);
    access("rd_after_rst", 32'h0000_0040, 32'h0, 4'b1111, 1'b0, 6, 6, 32'h00667788);

    // Back-to-back read at the top of the SRAM.
    base = log_adr.size();
    access("rd_b2b", 32'h0000_03FC, 32'h0, 4'b1111, 1'b0, 6, 6, 32'hEFBEADDE);
    chk_log("rd_b2b_l0", base + 0, 10'h3FC, 8'h00, 1'b0);
    chk_log("rd_b2b_l3", base + 3, 10'h3FF, 8'h00, 1'b0);

    @(negedge i_clk);
    chk("ack_total", 32'(acks), 32'(requests));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
